// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction buffer: circular array of {instrucao, pc_incr} with an occupancy counter.
// Outputs depend only on registered state; an empty queue presents an all-zero word (NOP) to decode.
module fetch_decode_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instrucao,
  input  logic [31:0]                in_pc_incr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instrucao,
  output logic [31:0]                out_pc_incr,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [63:0]    mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           push, pop;

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Mask the head so stale array contents never leak while empty.
  assign out_instrucao = out_valid ? mem_q[rd_ptr_q][63:32] : 32'h0;
  assign out_pc_incr   = out_valid ? mem_q[rd_ptr_q][31:0]  : 32'h0;
  assign count         = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Array storage needs no reset; visibility is governed by count.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q] <= {in_instrucao, in_pc_incr};
    end
  end

endmodule

// File: doc/fetch_decode_queue.md
# fetch_decode_queue

Instruction buffer between the fetch unit and the decode stage of the MIPS pipeline. It holds up to DEPTH fetched words, each stored with its PC+4 value, and decouples fetch from decode stalls with a valid/ready handshake on both sides. A synchronous flush discards every buffered entry when a branch or jump redirects the PC. When the buffer is empty it presents an all-zero word to decode, which MIPS executes as a NOP (sll $0,$0,0).

## Interface
- DEPTH, 4, number of entries; must be a power of two and at least 2.
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_valid  input  1  fetch presents a word this cycle.
- in_ready  output  1  queue accepts a word this cycle; equals (count < DEPTH).
- in_instrucao  input  32  fetched instruction word.
- in_pc_incr  input  32  PC+4 for that instruction.
- out_valid  output  1  head entry present; equals (count != 0).
- out_ready  input  1  decode consumes the head entry this cycle.
- out_instrucao  output  32  head instruction; 32'h0 when out_valid=0.
- out_pc_incr  output  32  head PC+4; 32'h0 when out_valid=0.
- flush  input  1  discard all entries at the next edge.
- count  output  $clog2(DEPTH)+1  current occupancy, range 0..DEPTH.

## Operation
- Storage: a circular array of DEPTH entries, each {instrucao, pc_incr}. Write pointer wr_ptr and read pointer rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. A separate occupancy counter `count` is kept.
- push = in_valid & in_ready. On push, the entry at wr_ptr is written and wr_ptr advances by 1.
- pop = out_valid & out_ready. On pop, rd_ptr advances by 1.
- count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, with both pointers advancing.
  - neither: unchanged.
- Outputs are registered with no combinational path between the two sides:
  - in_ready depends only on count.
  - out_valid and out_* depend only on count and the array.
  - Consequence: when the queue is full, in_ready=0 even if out_ready=1 in the same cycle.
- Empty output: out_instrucao and out_pc_incr are forced to 0 whenever count=0. Decode therefore always sees a NOP while nothing is buffered.
- Flush (synchronous): at the next edge, count, wr_ptr and rd_ptr all go to 0.
  - A push or pop in the same cycle as flush is discarded.
  - Stale array contents are never visible, because outputs are masked while count=0.
  - in_ready stays at its pre-flush value during the flush cycle. Fetch must deassert in_valid for that cycle or accept that the word is dropped.
- Reset (asynchronous): count, wr_ptr and rd_ptr go to 0. Array contents need not be cleared.
- Reset values of outputs: in_ready=1, out_valid=0, out_instrucao=0, out_pc_incr=0, count=0.
- Writes with in_valid=1 while in_ready=0 are ignored; no state changes. Pops with count=0 are likewise ignored.

## Timing
- Latency: a word pushed at edge N is visible on out_* starting after edge N, i.e. one cycle from in_valid to out_valid when the queue is empty. There is no fall-through bypass.
- Throughput: one push and one pop per cycle while 0 < count < DEPTH.
- The head entry stays stable on out_* while out_ready=0.
- Full is reached after DEPTH pushes with no pops. From full, in_ready rises the cycle after the first pop.
- Reset asserted mid-operation: state clears immediately, without waiting for clk. The first push may occur at the first edge after reset deasserts.
- Flush takes priority over push and pop. Reset takes priority over everything.

## Test plan
- Reset then single word: after reset, push {32'h20080005, 32'h4}. Required: out_valid=0, out_instrucao=0 and count=0 before the edge. After one edge: out_valid=1, out_instrucao=32'h20080005, out_pc_incr=32'h4, count=1.
- Fill to full: push 4 words (PC+4 = 4, 8, 12, 16) with out_ready=0. Required: count=4 and in_ready=0; a fifth push with 32'hDEADBEEF is ignored. Then drain with out_ready=1. Required: words appear in order 4, 8, 12, 16, then out_valid=0 with out_* = 0.
- Simultaneous push/pop at count=2: count stays 2 for 8 cycles, the sequence emerges in order, and pointers wrap past index 3 with no loss or duplication.
- Flush with pending push: count=3, and in the same cycle flush=1, in_valid=1, out_ready=1. Required after the edge: count=0, out_valid=0, out_instrucao=0. The next push, 32'h08000010, appears as the head one cycle later.
- Backpressure: hold out_ready=0 for 5 cycles with head 32'h8C090000. Required: out_instrucao stays 32'h8C090000 and count does not decrease.
- Async reset mid-stream: assert reset between edges at count=3. Required: count=0, out_valid=0 and in_ready=1 immediately, before the next clk edge.
